// File: rtl/fpu_pipe_ctrl.sv
// FP control pipeline: destination tags and write flags through E1..E_STAGES and W,
// iterative divide/sqrt stall sequencing, and RAW hazard / forwarding selection.
module fpu_pipe_ctrl #(
    parameter int STAGES      = 3,
    parameter int RN_W        = 5,
    parameter int DIV_CYCLES  = 24,
    parameter int SQRT_CYCLES = 26
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     issue_v,
    input  logic [2:0]               fc,
    input  logic                     wf,
    input  logic [RN_W-1:0]          fd,
    input  logic [RN_W-1:0]          fs,
    input  logic [RN_W-1:0]          ft,
    input  logic                     use_fs,
    input  logic                     use_ft,
    input  logic                     ein1,
    input  logic                     ein2,
    output logic                     e,
    output logic                     st_ds,
    output logic                     raw_stall,
    output logic [1:0]               fwd_s,
    output logic [1:0]               fwd_t,
    output logic [STAGES*RN_W-1:0]   en,
    output logic [STAGES-1:0]        ew,
    output logic [RN_W-1:0]          wn,
    output logic                     ww,
    output logic                     ds_busy
);
    localparam int MAXC  = (DIV_CYCLES > SQRT_CYCLES) ? DIV_CYCLES : SQRT_CYCLES;
    localparam int CNT_W = (MAXC > 2) ? $clog2(MAXC) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [STAGES-1:0]           ew_q;
    logic [STAGES-1:0][RN_W-1:0] en_q;
    logic [RN_W-1:0]             wn_q;
    logic                        ww_q;
    logic                        cancel, iter_in;
    logic [1:0][RN_W-1:0]        src;
    logic [1:0]                  use_v, stl;
    logic [1:0][1:0]             fwd;

    assign cancel  = ~ein2;
    assign ds_busy = (state_q == BUSY);
    assign st_ds   = ds_busy & ~cancel;
    assign e       = ein1 & ~st_ds;
    assign iter_in = issue_v & ~raw_stall & (fc[2:1] == 2'b11);

    // E1 write flag is only visible once qualified by ein2; a cancelled op is a bubble.
    always_comb begin
        ew    = ew_q;
        ew[0] = ew_q[0] & ein2;
    end

    assign en = en_q;
    assign wn = wn_q;
    assign ww = ww_q;

    // Nearest in-flight producer wins; anything still in E1..E(STAGES-1) cannot forward yet.
    always_comb begin
        src   = {ft, fs};
        use_v = {use_ft, use_fs};
        stl   = '0;
        fwd   = '0;
        for (int x = 0; x < 2; x++) begin
            if (use_v[x]) begin
                if (ww_q && wn_q == src[x])
                    fwd[x] = 2'd2;
                if (ew[STAGES-1] && en_q[STAGES-1] == src[x])
                    fwd[x] = 2'd1;
                for (int k = 0; k < STAGES-1; k++) begin
                    if (ew[k] && en_q[k] == src[x]) begin
                        stl[x] = 1'b1;
                        fwd[x] = 2'd0;
                    end
                end
            end
        end
    end

    assign raw_stall = issue_v & (|stl);
    assign fwd_s     = fwd[0];
    assign fwd_t     = fwd[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (e && iter_in) begin
                    state_d = BUSY;
                    cnt_d   = fc[0] ? CNT_W'(SQRT_CYCLES-1) : CNT_W'(DIV_CYCLES-1);
                end
            end
            BUSY: begin
                if (cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ein1) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ew_q <= '0;
            en_q <= '0;
            wn_q <= '0;
            ww_q <= 1'b0;
        end else if (e) begin
            ew_q[0] <= issue_v & wf & ~raw_stall;
            en_q[0] <= fd;
            for (int k = 1; k < STAGES; k++) begin
                ew_q[k] <= ew[k-1];
                en_q[k] <= en_q[k-1];
            end
            ww_q <= ew[STAGES-1];
            wn_q <= en_q[STAGES-1];
        end
    end
endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Self-checking bench for fpu_pipe_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the tag pipeline and divider.
module tb_fpu_pipe_ctrl;
    localparam int S  = 3;
    localparam int RN = 5;
    localparam int DC = 24;
    localparam int SC = 26;

    logic          clk, clrn, issue_v, wf, use_fs, use_ft, ein1, ein2;
    logic [2:0]    fc;
    logic [RN-1:0] fd, fs, ft;
    logic          e, st_ds, raw_stall, ww, ds_busy;
    logic [1:0]    fwd_s, fwd_t;
    logic [S*RN-1:0] en;
    logic [S-1:0]  ew;
    logic [RN-1:0] wn;

    fpu_pipe_ctrl #(.STAGES(S), .RN_W(RN), .DIV_CYCLES(DC), .SQRT_CYCLES(SC)) dut (
        .clk(clk), .clrn(clrn), .issue_v(issue_v), .fc(fc), .wf(wf), .fd(fd),
        .fs(fs), .ft(ft), .use_fs(use_fs), .use_ft(use_ft), .ein1(ein1), .ein2(ein2),
        .e(e), .st_ds(st_ds), .raw_stall(raw_stall), .fwd_s(fwd_s), .fwd_t(fwd_t),
        .en(en), .ew(ew), .wn(wn), .ww(ww), .ds_busy(ds_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: index 0..S-1 are E1..E_S, index S is W. Divider tracked as remaining stall edges.
    logic          mw [0:S];
    logic [RN-1:0] mn [0:S];
    logic          m_busy;
    int            m_rem;

    logic          x_e, x_st, x_raw, x_ww;
    logic [1:0]    x_fs, x_ft;
    logic [S-1:0]  x_ew;
    logic [S*RN-1:0] x_en;
    logic [RN-1:0] x_wn;

    task automatic model_reset();
        for (int j = 0; j <= S; j++) begin
            mw[j] = 1'b0;
            mn[j] = '0;
        end
        m_busy = 1'b0;
        m_rem  = 0;
    endtask

    // Index of nearest stage writing r (E1 first), or -1.
    function automatic int nearest(input logic [RN-1:0] r);
        for (int j = 0; j <= S; j++) begin
            logic f;
            f = (j == 0) ? (mw[0] & ein2) : mw[j];
            if (f && mn[j] == r) return j;
        end
        return -1;
    endfunction

    task automatic src_eval(input logic [RN-1:0] r, input logic u,
                            output logic stall, output logic [1:0] sel);
        int j;
        stall = 1'b0;
        sel   = 2'd0;
        if (u) begin
            j = nearest(r);
            if (j >= 0 && j < S-1) stall = 1'b1;
            else if (j == S-1)     sel = 2'd1;
            else if (j == S)       sel = 2'd2;
        end
    endtask

    task automatic model_eval();
        logic ss, ts;
        for (int k = 0; k < S; k++) begin
            x_ew[k] = mw[k];
            x_en[k*RN +: RN] = mn[k];
        end
        x_ew[0] = mw[0] & ein2;
        x_ww = mw[S];
        x_wn = mn[S];
        x_st = m_busy & ein2;
        x_e  = ein1 & ~x_st;
        src_eval(fs, use_fs, ss, x_fs);
        src_eval(ft, use_ft, ts, x_ft);
        x_raw = issue_v & (ss | ts);
    endtask

    task automatic model_update();
        if (!m_busy) begin
            if (x_e && issue_v && !x_raw && fc[2:1] == 2'b11) begin
                m_busy = 1'b1;
                m_rem  = (fc[0] ? SC : DC) - 1;
            end
        end else if (!ein2) begin
            m_busy = 1'b0;
            m_rem  = 0;
        end else if (ein1) begin
            m_rem--;
            if (m_rem == 0) m_busy = 1'b0;
        end
        if (x_e) begin
            for (int j = S; j >= 1; j--) begin
                mw[j] = (j == 1) ? x_ew[0] : mw[j-1];
                mn[j] = mn[j-1];
            end
            mw[0] = issue_v & wf & ~x_raw;
            mn[0] = fd;
        end
    endtask

    // Called at the falling edge with inputs set; checks, then consumes one rising edge.
    task automatic step();
        if (!clrn) model_reset();
        #1;
        model_eval();
        chk("e", e, x_e);
        chk("st_ds", st_ds, x_st);
        chk("ds_busy", ds_busy, m_busy);
        chk("raw_stall", raw_stall, x_raw);
        chk("fwd_s", fwd_s, x_fs);
        chk("fwd_t", fwd_t, x_ft);
        chk("ew", ew, x_ew);
        chk("en", en, x_en);
        chk("ww", ww, x_ww);
        chk("wn", wn, x_wn);
        @(posedge clk);
        if (clrn) model_update();
        @(negedge clk);
    endtask

    task automatic idle_in();
        issue_v = 0; fc = 3'b000; wf = 0; fd = '0; fs = '0; ft = '0;
        use_fs = 0; use_ft = 0; ein1 = 1; ein2 = 1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [RN-1:0] d);
        issue_v = 1; fc = f; wf = 1; fd = d;
    endtask

    int cnt;

    initial begin
        clrn = 0;
        idle_in();
        model_reset();
        @(negedge clk);
        step();
        chk("rst_busy", ds_busy, 0);
        chk("rst_ww", ww, 0);
        clrn = 1;
        step();

        // Single-pass op flows E1 -> E2 -> E3 -> W.
        issue(3'b000, 5'd7);
        step();
        idle_in();
        chk("add_e1", en[RN-1:0], 7);
        chk("add_e1w", ew[0], 1);
        step();
        chk("add_e2", en[2*RN-1:RN], 7);
        step();
        chk("add_e3", en[3*RN-1:2*RN], 7);
        step();
        chk("add_ww", ww, 1);
        chk("add_wn", wn, 7);
        step();

        // fdiv: 23 stall cycles, then advance to E2.
        issue(3'b110, 5'd9);
        step();
        idle_in();
        cnt = 0;
        for (int g = 0; g < 60 && st_ds; g++) begin
            cnt++;
            chk("div_e_low", e, 0);
            step();
        end
        chk("div_stall_cycles", cnt, DC-1);
        chk("div_e_back", e, 1);
        step();
        chk("div_in_e2", en[2*RN-1:RN], 9);
        chk("div_e2_w", ew[1], 1);
        step();

        // fdiv with two ein1-low cycles mid-op.
        issue(3'b110, 5'd11);
        step();
        idle_in();
        cnt = 0;
        for (int g = 0; g < 60 && st_ds; g++) begin
            cnt++;
            ein1 = !(cnt == 10 || cnt == 11);
            step();
        end
        ein1 = 1;
        chk("div_ein1_stall_cycles", cnt, DC+1);
        for (int g = 0; g < 4; g++) step();

        // fsqrt cancelled in its fifth busy cycle.
        issue(3'b111, 5'd5);
        step();
        idle_in();
        for (int g = 0; g < 4; g++) step();
        chk("sqrt_busy", ds_busy, 1);
        ein2 = 0;
        #1;
        chk("sqrt_cancel_ew0", ew[0], 0);
        chk("sqrt_cancel_st", st_ds, 0);
        chk("sqrt_cancel_e", e, 1);
        step();
        ein2 = 1;
        chk("sqrt_idle_next", ds_busy, 0);
        for (int g = 0; g < 5; g++) begin
            chk("sqrt_no_ww", ww, 0);
            step();
        end

        // RAW stall, then forward from E3 and W.
        issue(3'b000, 5'd3);
        step();
        issue(3'b000, 5'd10);
        fs = 5'd3; use_fs = 1;
        #1;
        chk("raw_e1", raw_stall, 1);
        step();
        chk("raw_bubble", ew[0], 0);
        chk("raw_e2", raw_stall, 1);
        step();
        issue_v = 0;
        #1;
        chk("raw_e3_stall", raw_stall, 0);
        chk("raw_e3_fwd", fwd_s, 1);
        step();
        chk("raw_w_fwd", fwd_s, 2);
        use_fs = 0;
        #1;
        chk("raw_nouse", fwd_s, 0);
        step();
        idle_in();
        for (int g = 0; g < 3; g++) step();

        // Same register in E3 and W: E3 wins.
        issue(3'b000, 5'd3);
        step();
        step();
        idle_in();
        step();
        step();
        fs = 5'd3; use_fs = 1; ft = 5'd3; use_ft = 1;
        #1;
        chk("near_fwd_s", fwd_s, 1);
        chk("near_fwd_t", fwd_t, 1);
        step();
        idle_in();

        // Reset with a full pipe and a divide in flight.
        for (int g = 0; g < 4; g++) begin
            issue(3'b000, 5'(g + 20));
            step();
        end
        issue(3'b110, 5'd2);
        step();
        idle_in();
        step();
        clrn = 0; ein1 = 0;
        #1;
        chk("rst_st_ds", st_ds, 0);
        chk("rst_busy_async", ds_busy, 0);
        chk("rst_en", en, 0);
        chk("rst_ew", ew, 0);
        chk("rst_ww_async", ww, 0);
        chk("rst_e_tracks0", e, 0);
        ein1 = 1;
        #1;
        chk("rst_e_tracks1", e, 1);
        step();
        clrn = 1;
        step();
        chk("rst_no_residue", ds_busy, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            issue_v = 1'($urandom_range(0, 1));
            fc      = ($urandom_range(0, 9) == 0) ? {2'b11, 1'($urandom_range(0, 1))}
                                                 : 3'($urandom_range(0, 5));
            wf      = 1'($urandom_range(0, 3) != 0);
            fd      = 5'($urandom_range(0, 7));
            fs      = 5'($urandom_range(0, 7));
            ft      = 5'($urandom_range(0, 7));
            use_fs  = 1'($urandom_range(0, 1));
            use_ft  = 1'($urandom_range(0, 1));
            ein1    = 1'($urandom_range(0, 9) != 0);
            ein2    = 1'($urandom_range(0, 19) != 0);
            clrn    = 1'($urandom_range(0, 299) != 0);
            step();
        end
        clrn = 1;
        idle_in();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_pipe_ctrl.md
# fpu_pipe_ctrl

Parametrised control pipeline for the floating-point unit: carries destination-register tags and write flags through E1..E_STAGES and W, sequences an iterative divide/square-root unit with a stall counter, and detects read-after-write hazards against in-flight FP instructions. It sits between the FP decode logic in ID and the FP datapath (adder/multiplier/divider), and supplies the datapath's advance enable `e`. It supersedes the fixed three-stage tag pipeline with a hard-wired zero divide/sqrt stall.

## Interface
Parameters:
- STAGES, 3, execute stages E1..E_STAGES before W (>=2)
- RN_W, 5, register-number width
- DIV_CYCLES, 24, total E1 residency of fdiv (>=2)
- SQRT_CYCLES, 26, total E1 residency of fsqrt (>=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- clrn  in  1  reset, asynchronous, active-low
- issue_v  in  1  ID presents a valid FP instruction
- fc  in  3  FP control; 3'b110 fdiv, 3'b111 fsqrt, others single-pass
- wf  in  1  instruction writes FP regfile
- fd  in  RN_W  destination register
- fs, ft  in  RN_W  source registers
- use_fs, use_ft  in  1  source actually read
- ein1  in  1  no cache stall
- ein2  in  1  0 cancels the instruction in E1
- e  out  1  pipeline advance, ein1 & ~st_ds
- st_ds  out  1  stall from in-progress fdiv/fsqrt
- raw_stall  out  1  ID must hold: unforwardable RAW hazard
- fwd_s, fwd_t  out  2  source select: 0 regfile, 1 E_STAGES result, 2 W result
- en  out  STAGES*RN_W  stage dest regs, E1 in bits [RN_W-1:0]
- ew  out  STAGES  stage write flags, E1 in bit 0 (E1 flag already gated by ein2)
- wn  out  RN_W  writeback register
- ww  out  1  writeback enable
- ds_busy  out  1  iterative unit occupied

## Operation
- Pipeline registers: E1 {w0,n,iter}, E2..E_STAGES {w,n}, W {w,n}. On edge with e=1: E1 <= {issue_v & wf & ~raw_stall, fd, issue_v & ~raw_stall & fc[2:1]==2'b11}; E(k+1) <= Ek (E1 flag taken as w0 & ein2); W <= E_STAGES. With e=0 all hold.
- ew[0] = E1.w0 & ein2; cancelled E1 instruction is a bubble from that cycle on.
- Iterative FSM, states IDLE, BUSY. IDLE->BUSY on edge where e=1 and an iterative op enters E1; counter cnt loaded DIV_CYCLES-1 or SQRT_CYCLES-1. In BUSY, cnt decrements on every edge with ein1=1; holds when ein1=0. cnt==1 decrementing -> IDLE. ds_busy = (state==BUSY).
- st_ds = ds_busy & ~cancel, cancel = ~ein2. Cancel in BUSY -> IDLE, cnt <= 0 next edge.
- Hazard compare, per source x in {s,t} with use_x=1, nearest stage wins (E1 highest priority): match in E1..E(STAGES-1) with write flag -> raw_stall=1; nearest match E_STAGES -> fwd_x=1; nearest match W -> fwd_x=2; none -> 0. fwd_x is 0 when use_x=0. raw_stall is 0 when issue_v=0.
- Reset (clrn=0, async): all stage flags/numbers, wn, ww, cnt cleared, state IDLE. Outputs during reset: st_ds=0, ds_busy=0, raw_stall=0, fwd_*=0, ew=0, en=0, ww=0, wn=0, e=ein1.

## Timing
- Single-pass op: issued at edge T (into E1) -> in W after edge T+STAGES with no stalls; ww high that cycle.
- Iterative op of N cycles entering E1 at edge T: st_ds high for N-1 cycles after T (ein1=1 throughout); e=0 those cycles; advances to E2 at edge T+N.
- ein1=0 during BUSY extends stall one cycle per low cycle.
- Reset asserted mid-BUSY: st_ds drops immediately (async); no residue after release.
- Simultaneous cancel and cnt==1: treated as cancel; result identical (IDLE).
- raw_stall and st_ds both high: e=0 regardless; E1 holds iterative op, no bubble inserted until e=1.

## Test plan
- Reset: clrn=0 with pipe full -> all tag outputs 0, st_ds=0 immediately; e tracks ein1.
- Add fd=7, wf=1 at edge 0, STAGES=3 -> en E1=7 cycle 1, E2 cycle 2, E3 cycle 3, ww=1 wn=7 cycle 4.
- fdiv DIV_CYCLES=24 -> st_ds high exactly 23 cycles, e=0 those cycles; ein1 pulsed low 2 cycles mid-op -> 25 stall cycles.
- fsqrt entered, ein2=0 on cycle 5 of BUSY -> ew[0]=0 same cycle, st_ds=0 same cycle, ds_busy=0 next cycle; no ww for it.
- RAW: fd=3 in E1, next issue fs=3 use_fs=1 -> raw_stall=1 and E1 loads bubble; when producer in E3 -> fwd_s=1, raw_stall=0; producer in W -> fwd_s=2; use_fs=0 -> fwd_s=0.
- fd=3 in both E3 and W, fs=3 -> fwd_s=1 (nearest wins).
